power_iteration_ctrl: RTL
=========================

// Module: power_iteration_ctrl
// PURPOSE
//  Initiator for the single-step eigen-iteration block (start/f handshake, sticky f, cleared only by its reset).
//  Seeds the step block with an initial vector, re-arms it each iteration via step_rst, and feeds back the normalised result.
//  Stops on convergence, on MAX_ITER, or on step timeout; presents the dominant eigenvector to the ICA/whitening stage.
// PARAMETERS
//  SIZE_N     8    vector length (rows); must match step block SIZE_N
//  MAX_ITER   32   iteration cap, >=1
//  MANT_BITS  20   upper mantissa bits compared for convergence (0..52)
//  TIMEOUT    4096 max cycles waiting for step_f per iteration, >=2
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 reset, asynchronous, active-high
//  start          in   1                 1-cycle pulse; begin run (accepted in IDLE or DONE only)
//  init_vec       in   double[SIZE_N][1] seed vector, sampled on accepted start
//  step_start     out  1                 start level to step block
//  step_rst       out  1                 reset to step block
//  step_vec_in    out  double[SIZE_N][1] current iterate, to step block vector_in
//  step_vec_out   in   double[SIZE_N][1] normalised result from step block
//  step_f         in   1                 step-block finished (level, sticky)
//  vec_out        out  double[SIZE_N][1] final iterate; valid while done=1
//  iterations     out  $clog2(MAX_ITER+1) completed step count
//  busy           out  1                 run in progress
//  done           out  1                 run finished (level, held until next start or rst)
//  converged      out  1                 done with convergence met
//  timeout        out  1                 done due to step timeout
// BEHAVIOUR
//  double = 64-bit fp_double word; all comparisons on raw bits, no FP arithmetic in this block.
//  Reset: state IDLE; vec_reg, vec_out, iterations, busy, done, converged, timeout, step_start = 0.
//   step_rst = rst OR (state==CLEAR), so the step block is held in reset while rst is high.
//  step_vec_in = vec_reg continuously.
//  FSM:
//   IDLE/DONE: start -> vec_reg<=init_vec, iterations<=0, clear done/converged/timeout, busy<=1, -> CLEAR.
//   CLEAR: step_rst=1 for exactly 1 cycle; wdog<=0; -> ISSUE.
//   ISSUE: step_start=1; -> RUN.
//   RUN: step_start=1 held; wdog++ per cycle.
//    step_f=1 -> cand<=step_vec_out, -> CHECK.
//    else wdog==TIMEOUT-1 -> timeout<=1, -> DONE.
//   CHECK: step_start=0; match = for all i, cand[i][63:52-MANT_BITS]==vec_reg[i][63:52-MANT_BITS].
//    vec_reg<=cand; iterations++.
//    match -> converged<=1, -> DONE.
//    else iterations+1==MAX_ITER -> DONE (converged=0).
//    else -> CLEAR.
//   DONE: done=1, busy=0, vec_out<=vec_reg on entry; step_start=0.
//  Per-iteration overhead: 3 cycles (CLEAR, ISSUE, CHECK) plus step latency counted from first step_start cycle.
//  step_f and timeout limit in the same RUN cycle: step_f wins.
//  start while busy: ignored, no side effect.
//  step_f seen in any state other than RUN: ignored (stale sticky f is cleared by the CLEAR pulse).
//  rst mid-run: immediate return to reset values; no partial vec_out update.
//  iterations never exceeds MAX_ITER; on timeout it holds the count of completed steps.
//  On timeout, vec_out = last accepted iterate (init_vec if first step).
// TESTING (behavioural step model: fixed latency 10 cycles, scripted output per call)
//  1. init all 0x3FD6A09E667F3BCD, model echoes input
//     -> done after 1 step, iterations=1, converged=1, vec_out==init, 14 cycles start->done.
//  2. Model returns 3 distinct vectors, then repeats the 3rd
//     -> iterations=4, converged=1, vec_out = 3rd vector; exactly 4 step_rst pulses.
//  3. MAX_ITER=16, model alternates sign of element 0 each call
//     -> iterations=16, converged=0, timeout=0, done=1.
//  4. TIMEOUT=64, model never raises step_f
//     -> timeout=1, done=1, iterations=0, 64 RUN cycles, vec_out==init_vec.
//  5. rst asserted during RUN of step 2
//     -> all outputs 0, step_rst=1 and step_start=0 while rst; a following start runs cleanly from iterations=0.
//  6. start pulsed during RUN -> no effect; start in DONE -> new run, done/converged cleared next cycle.
//  7. MANT_BITS=20, results differ only in mantissa bit 0 -> converged=1.

Source files
------------

// File: rtl/power_iteration_ctrl.sv
// power_iteration_ctrl
//  Drives a single-step eigen-iteration block repeatedly. It seeds the block with a start
//  vector and re-arms it with step_rst before each step. Each normalised result is fed back
//  as the next iterate. The run stops on convergence (the upper mantissa bits stop changing),
//  on the iteration cap, or when a step does not finish within TIMEOUT cycles.
// Ports:
//  clk, rst                  clock; asynchronous active-high reset
//  start                     1-cycle run request, honoured only when idle or done
//  init_vec                  seed vector, SIZE_N packed 64-bit words, element i at [i*64 +: 64]
//  step_start/step_rst       start level and reset to the step block
//  step_vec_in/step_vec_out  current iterate out, normalised result in
//  step_f                    step block finished (sticky level)
//  vec_out                   final iterate, valid while done
//  iterations                completed steps
//  busy/done/converged/timeout  run status
module power_iteration_ctrl #(
  parameter int SIZE_N    = 8,
  parameter int MAX_ITER  = 32,
  parameter int MANT_BITS = 20,
  parameter int TIMEOUT   = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SIZE_N*64-1:0]          init_vec,
  output logic                          step_start,
  output logic                          step_rst,
  output logic [SIZE_N*64-1:0]          step_vec_in,
  input  logic [SIZE_N*64-1:0]          step_vec_out,
  input  logic                          step_f,
  output logic [SIZE_N*64-1:0]          vec_out,
  output logic [$clog2(MAX_ITER+1)-1:0] iterations,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic                          timeout
);

  localparam int IW  = $clog2(MAX_ITER+1);
  localparam int WW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Lowest bit position taking part in the convergence compare (sign, exponent, top mantissa).
  localparam int LSB = 52 - MANT_BITS;
  localparam int CW  = 64 - LSB;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [SIZE_N*64-1:0]  vec_reg;
  logic [SIZE_N*64-1:0]  cand;
  logic [WW-1:0]         wdog;
  logic                  match;
  logic                  wdog_last;
  logic                  iter_last;
  logic                  accept;

  assign wdog_last   = (wdog == WW'(TIMEOUT - 1));
  assign iter_last   = (iterations == IW'(MAX_ITER - 1));
  assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
  assign step_vec_in = vec_reg;

  // Convergence: every element's compared field is unchanged between iterates.
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < SIZE_N; i++) begin
      if (cand[i*64+LSB +: CW] != vec_reg[i*64+LSB +: CW]) begin
        match = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_CLEAR;
      S_CLEAR:        state_nxt = S_ISSUE;
      S_ISSUE:        state_nxt = S_RUN;
      S_RUN: begin
        // A finishing step takes priority over the watchdog in the same cycle.
        if (step_f)         state_nxt = S_CHECK;
        else if (wdog_last) state_nxt = S_DONE;
      end
      S_CHECK: begin
        if (match || iter_last) state_nxt = S_DONE;
        else                    state_nxt = S_CLEAR;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Output logic; step_rst also follows rst so the step block resets with us.
  always_comb begin
    step_start = (state == S_ISSUE) || (state == S_RUN);
    step_rst   = rst || (state == S_CLEAR);
    busy       = (state == S_CLEAR) || (state == S_ISSUE) ||
                 (state == S_RUN)   || (state == S_CHECK);
    done       = (state == S_DONE);
  end

  // Datapath and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_reg    <= '0;
      cand       <= '0;
      vec_out    <= '0;
      iterations <= '0;
      wdog       <= '0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            vec_reg    <= init_vec;
            iterations <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        S_CLEAR: wdog <= '0;
        S_RUN: begin
          wdog <= wdog + 1'b1;
          if (step_f) begin
            cand <= step_vec_out;
          end else if (wdog_last) begin
            // No step completed this iteration: report the last accepted iterate.
            timeout <= 1'b1;
            vec_out <= vec_reg;
          end
        end
        S_CHECK: begin
          vec_reg    <= cand;
          iterations <= iterations + 1'b1;
          if (match) begin
            converged <= 1'b1;
            vec_out   <= cand;
          end else if (iter_last) begin
            vec_out   <= cand;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
